qsys_lab_sram_arbiter: RTL and testbench
========================================

# qsys_lab_sram_arbiter

Two-port arbiter that shares the single-port on-chip SRAM (4096 × 32, byte-enabled, 1-cycle read latency) between two Avalon-MM masters, e.g. the processor data master and a DMA/accelerator master. It sits between the masters and the SRAM's s1 port. It provides round-robin arbitration, one command per cycle, per-master read-data routing and an optional lock for atomic read-modify-write sequences.

## Interface
Parameters:
- ADDR_W, 12: SRAM word-address width.
- DATA_W, 32: data width.
- BE_W, DATA_W/8: byte-enable width.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- mN_address  in  ADDR_W  master N word address (N = 0, 1, same set per master).
- mN_byteenable  in  BE_W  master N byte enables.
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request.
- mN_writedata  in  DATA_W  master N write data.
- mN_lock  in  1  master N lock request; active only with QSYS_LAB_SRAM_ARB_LOCK_EN.
- mN_waitrequest  out  1  command not accepted this cycle.
- mN_readdata  out  DATA_W  read data, valid with readdatavalid.
- mN_readdatavalid  out  1  read data strobe, 1 cycle.
- sram_address  out  ADDR_W  to SRAM address.
- sram_byteenable  out  BE_W  to SRAM byteenable.
- sram_writedata  out  DATA_W  to SRAM writedata.
- sram_chipselect  out  1  SRAM access this cycle.
- sram_write  out  1  SRAM write this cycle.
- sram_clken  out  1  SRAM clock enable; 0 in reset, 1 otherwise.
- sram_readdata  in  DATA_W  SRAM read data.

## Operation
- reqN = mN_read | mN_write. If both read and write are asserted, the command is treated as a write.
- State register: ARB, LOCK0, LOCK1. Round-robin pointer rr_last (last granted master).
- ARB state: a single requester is granted. If both request, grant goes to the master ≠ rr_last. rr_last updates to the granted master on every accepted command.
- LOCKN state: only master N can be granted. The other master sees waitrequest = 1.
- Grant is combinational in the same cycle. The granted master's address, byteenable and writedata are muxed to the SRAM, with sram_chipselect = 1 and sram_write = granted write. mN_waitrequest = reqN & ~grantN.
- With no grant: sram_chipselect = 0, sram_write = 0, and the muxed fields are held at master 0 values.
- Accepted read: rd_pend <= 1 and rd_owner <= N. Next cycle: mN_readdatavalid = rd_pend & (rd_owner == N), and mN_readdata = sram_readdata (passthrough to both masters).
- Lock transitions (only when compiled in):
  - ARB → LOCKN when master N's command is accepted with mN_lock = 1.
  - LOCKN → ARB at the clock edge ending any cycle in which mN_lock = 0. Master N keeps exclusive grant in that cycle.
- Reset (async, any time):
  - state = ARB, rr_last = 1 so master 0 wins the first tie.
  - rd_pend = 0, so any in-flight read is dropped and produces no readdatavalid.
  - mN_waitrequest = 1, mN_readdatavalid = 0, sram_chipselect = 0, sram_write = 0, sram_clken = 0, mN_readdata = 0.

## Timing
- Command acceptance: 0 extra cycles for an uncontended request.
- Read latency: readdatavalid exactly 1 cycle after acceptance. Fully pipelined, so back-to-back reads give 1 result per cycle.
- Write: completes on the accepting edge. No response strobe.
- Contention: the losing master waits 1 cycle when both stream continuously, which gives strict alternation.
- Read of an address written in the previous cycle returns the new data, because the SRAM is single-port and accesses are sequential.

## Configuration
- QSYS_LAB_SRAM_ARB_LOCK_EN defined: the LOCK0/LOCK1 states and lock transitions are built.
- Not defined: mN_lock is ignored and the state is permanently ARB (pure round-robin).

## Structure
- Package qsys_lab_sram_arb_pkg holds:
  - the state enum (ARB, LOCK0, LOCK1);
  - default ADDR_W/DATA_W constants;
  - the master index type.
- Sub-module qsys_lab_rr_arb2: 2-way round-robin grant from req[1:0], rr_last and a mask input (used for lock). It outputs a one-hot grant.
- The top level holds the FSM, rd_pend/rd_owner pipeline and the SRAM mux.

## Test plan
- Single master: m0 writes 0xDEADBEEF at 0x010 with be=0xF, then reads 0x010 → m0_readdatavalid 1 cycle after acceptance with 0xDEADBEEF, m0_waitrequest never asserted.
- Byte enables: write 0x11223344, then write 0xAABBCCDD with be=0x5, read back → 0x11BB33DD.
- Contention: both masters issue reads every cycle from reset → grants alternate m0, m1, m0, …, each readdatavalid goes only to the issuing master with the correct data, no lost or duplicated responses.
- Lock (macro on): m1 reads 0x020 with lock=1, then m0 requests for 3 cycles while m1 writes 0x020 with lock=0 → m0 waitrequest held until the cycle after m1's unlocked write, then m0 is granted. With the macro off, the same stimulus alternates grants.
- Reset mid-read: assert reset_n = 0 in the cycle after a read is accepted → no readdatavalid, all outputs at reset values. First tie after release is granted to m0.

Source files
------------

// File: rtl/qsys_lab_sram_arb_pkg.sv
// Shared types and defaults for the two-master on-chip SRAM arbiter.
// QSYS_LAB_SRAM_ARB_LOCK_EN enables the lock states in the top level.
package qsys_lab_sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef logic master_idx_t;

endpackage

// File: rtl/qsys_lab_rr_arb2.sv
// Two-way round-robin grant; mask removes masters that may not be granted.
// On a tie the master that was not granted last wins.
module qsys_lab_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] live;

    always_comb begin
        live  = req & mask;
        grant = '0;
        case (live)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/qsys_lab_sram_arbiter.sv
// Shares a single-port SRAM between two Avalon-MM masters with round-robin grant.
// Define QSYS_LAB_SRAM_ARB_LOCK_EN to build the LOCK0/LOCK1 exclusive-access states.
module qsys_lab_sram_arbiter
    import qsys_lab_sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] sram_address,
    output logic [BE_W-1:0]   sram_byteenable,
    output logic [DATA_W-1:0] sram_writedata,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic              sram_clken,
    input  logic [DATA_W-1:0] sram_readdata
);

    arb_state_t  state_q, state_d;
    master_idx_t rr_last_q;
    master_idx_t rd_owner_q;
    logic        rd_pend_q;

    logic [1:0]  req;
    logic [1:0]  mask;
    logic [1:0]  grant;
    logic        grant_any;
    logic        grant_write;

    // Requests are suppressed while reset is held so nothing reaches the SRAM.
    assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

    qsys_lab_rr_arb2 u_rr_arb2 (
        .req     (req),
        .rr_last (rr_last_q),
        .mask    (mask),
        .grant   (grant)
    );

    assign grant_any   = |grant;
    assign grant_write = (grant[0] & m0_write) | (grant[1] & m1_write);

    always_comb begin
        mask = 2'b11;
        case (state_q)
            LOCK0:   mask = 2'b01;
            LOCK1:   mask = 2'b10;
            default: mask = 2'b11;
        endcase
    end

`ifdef QSYS_LAB_SRAM_ARB_LOCK_EN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (grant[0] && m0_lock) begin
                    state_d = LOCK0;
                end else if (grant[1] && m1_lock) begin
                    state_d = LOCK1;
                end
            end
            // Owner keeps exclusive grant through the cycle that drops lock.
            LOCK0: if (!m0_lock) state_d = ARB;
            LOCK1: if (!m1_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;

    always_comb begin
        state_d = ARB;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB;
            rr_last_q  <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= grant_any & ~grant_write;
            if (grant_any) begin
                rr_last_q  <= grant[1];
                rd_owner_q <= grant[1];
            end
        end
    end

    // Ungranted cycles leave master 0's fields on the SRAM bus.
    always_comb begin
        sram_address    = m0_address;
        sram_byteenable = m0_byteenable;
        sram_writedata  = m0_writedata;
        if (grant[1]) begin
            sram_address    = m1_address;
            sram_byteenable = m1_byteenable;
            sram_writedata  = m1_writedata;
        end
    end

    assign sram_chipselect = grant_any;
    assign sram_write      = grant_write;
    assign sram_clken      = reset_n;

    assign m0_waitrequest   = ~reset_n | (req[0] & ~grant[0]);
    assign m1_waitrequest   = ~reset_n | (req[1] & ~grant[1]);

    assign m0_readdatavalid = rd_pend_q & (rd_owner_q == 1'b0);
    assign m1_readdatavalid = rd_pend_q & (rd_owner_q == 1'b1);

    assign m0_readdata      = reset_n ? sram_readdata : '0;
    assign m1_readdata      = reset_n ? sram_readdata : '0;

endmodule

// File: tb/tb_qsys_lab_sram_arbiter.sv
// Scoreboard bench for qsys_lab_sram_arbiter with a behavioural 4096x32 SRAM.
// Honours QSYS_LAB_SRAM_ARB_LOCK_EN for the lock-sequence expectations.
module tb_qsys_lab_sram_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        lk;
        logic [11:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [11:0] sram_address;
    logic [3:0]  sram_byteenable;
    logic [31:0] sram_writedata;
    logic        sram_chipselect, sram_write, sram_clken;
    logic [31:0] sram_readdata;

    logic [31:0] sram_mem [4096];
    logic [31:0] model_mem [4096];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sram_clken && sram_chipselect) begin
            if (sram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_byteenable[b]) sram_mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
                end
            end else begin
                sram_readdata <= sram_mem[sram_address];
            end
        end
    end

    qsys_lab_sram_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_lock          (m0_lock),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_lock          (m1_lock),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .sram_address     (sram_address),
        .sram_byteenable  (sram_byteenable),
        .sram_writedata   (sram_writedata),
        .sram_chipselect  (sram_chipselect),
        .sram_write       (sram_write),
        .sram_clken       (sram_clken),
        .sram_readdata    (sram_readdata)
    );

    function automatic cmd_t idle();
        return '0;
    endfunction

    function automatic cmd_t rd(input logic [11:0] a, input logic lk);
        cmd_t c = '0;
        c.rd = 1'b1; c.a = a; c.be = 4'hF; c.lk = lk;
        return c;
    endfunction

    function automatic cmd_t wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be, input logic lk);
        cmd_t c = '0;
        c.wr = 1'b1; c.a = a; c.d = d; c.be = be; c.lk = lk;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input cmd_t c0, input cmd_t c1);
        m0_address = c0.a; m0_byteenable = c0.be; m0_read = c0.rd; m0_write = c0.wr;
        m0_writedata = c0.d; m0_lock = c0.lk;
        m1_address = c1.a; m1_byteenable = c1.be; m1_read = c1.rd; m1_write = c1.wr;
        m1_writedata = c1.d; m1_lock = c1.lk;
    endtask

    task automatic accept(input int m, input cmd_t c);
        exp_t e;
        if (c.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (c.be[b]) model_mem[c.a][8*b +: 8] = c.d[8*b +: 8];
            end
        end else begin
            e.data = model_mem[c.a];
            e.cyc  = cyc + 1;
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // One bus cycle: drive both masters, check grant decisions, log accepted commands.
    task automatic step(input string tag, input cmd_t c0, input cmd_t c1, input logic ew0, input logic ew1);
        logic exp_cs;
        @(negedge clk);
        drive(c0, c1);
        #1;
        exp_cs = ((c0.rd | c0.wr) & ~ew0) | ((c1.rd | c1.wr) & ~ew1);
        check({tag, ".wait0"}, {31'd0, m0_waitrequest}, {31'd0, ew0});
        check({tag, ".wait1"}, {31'd0, m1_waitrequest}, {31'd0, ew1});
        check({tag, ".cs"}, {31'd0, sram_chipselect}, {31'd0, exp_cs});
        if ((c0.rd || c0.wr) && !m0_waitrequest) accept(0, c0);
        if ((c1.rd || c1.wr) && !m1_waitrequest) accept(1, c1);
    endtask

    task automatic check_rd(input int m, input logic [31:0] d);
        exp_t e;
        checks++;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL rdv%0d_unexpected: got data %h at cycle %0d expected no response", m, d, cyc);
        end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            if (d !== e.data || cyc != e.cyc) begin
                errors++;
                $display("FAIL rdv%0d_data: got %h at cycle %0d expected %h at cycle %0d", m, d, cyc, e.data, e.cyc);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            #2;
            if (m0_readdatavalid) check_rd(0, m0_readdata);
            if (m1_readdatavalid) check_rd(1, m1_readdata);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".wait0"}, {31'd0, m0_waitrequest}, 32'd1);
        check({tag, ".wait1"}, {31'd0, m1_waitrequest}, 32'd1);
        check({tag, ".rdv0"}, {31'd0, m0_readdatavalid}, 32'd0);
        check({tag, ".rdv1"}, {31'd0, m1_readdatavalid}, 32'd0);
        check({tag, ".cs"}, {31'd0, sram_chipselect}, 32'd0);
        check({tag, ".we"}, {31'd0, sram_write}, 32'd0);
        check({tag, ".clken"}, {31'd0, sram_clken}, 32'd0);
        check({tag, ".rdata0"}, m0_readdata, 32'd0);
        check({tag, ".rdata1"}, m1_readdata, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(rd(12'h010, 1'b0), rd(12'h030, 1'b0));
        fork
            monitor_loop();
        join_none

        @(negedge clk);
        #1;
        reset_checks("por");
        @(negedge clk);
        drive(idle(), idle());
        reset_n = 1'b1;
        #1;
        check("por.clken_rel", {31'd0, sram_clken}, 32'd1);

        // Single master write then read-back, plus m1 seeding 0x020.
        step("wr010", wr(12'h010, 32'hDEADBEEF, 4'hF, 1'b0), idle(), 1'b0, 1'b0);
        step("rd010", rd(12'h010, 1'b0), idle(), 1'b0, 1'b0);
        step("wr020", idle(), wr(12'h020, 32'h01234567, 4'hF, 1'b0), 1'b0, 1'b0);

        // Byte-enable merge: expected 0x11BB33DD.
        step("be_w1", wr(12'h030, 32'h11223344, 4'hF, 1'b0), idle(), 1'b0, 1'b0);
        step("be_w2", wr(12'h030, 32'hAABBCCDD, 4'h5, 1'b0), idle(), 1'b0, 1'b0);
        step("be_rd", rd(12'h030, 1'b0), idle(), 1'b0, 1'b0);
        step("idle0", idle(), idle(), 1'b0, 1'b0);

        // Reset in the cycle after a read is accepted: response is dropped.
        step("rst_rd", rd(12'h010, 1'b0), idle(), 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        drive(rd(12'h010, 1'b0), rd(12'h030, 1'b0));
        #1;
        reset_checks("midrst");
        @(negedge clk);
        drive(idle(), idle());
        reset_n = 1'b1;

        // Continuous contention from reset: m0 first, then strict alternation.
        step("cont1", rd(12'h010, 1'b0), rd(12'h030, 1'b0), 1'b0, 1'b1);
        step("cont2", rd(12'h010, 1'b0), rd(12'h030, 1'b0), 1'b1, 1'b0);
        step("cont3", rd(12'h010, 1'b0), rd(12'h030, 1'b0), 1'b0, 1'b1);
        step("cont4", rd(12'h010, 1'b0), rd(12'h030, 1'b0), 1'b1, 1'b0);
        step("idle1", idle(), idle(), 1'b0, 1'b0);

        // Lock sequence; m1 was granted last.
        step("lk1", idle(), rd(12'h020, 1'b1), 1'b0, 1'b0);
`ifdef QSYS_LAB_SRAM_ARB_LOCK_EN
        step("lk2", rd(12'h010, 1'b0), rd(12'h020, 1'b1), 1'b1, 1'b0);
        step("lk3", rd(12'h010, 1'b0), wr(12'h020, 32'hCAFEF00D, 4'hF, 1'b0), 1'b1, 1'b0);
        step("lk4", rd(12'h010, 1'b0), idle(), 1'b0, 1'b0);
`else
        step("lk2", rd(12'h010, 1'b0), rd(12'h020, 1'b1), 1'b0, 1'b1);
        step("lk3", rd(12'h010, 1'b0), wr(12'h020, 32'hCAFEF00D, 4'hF, 1'b0), 1'b1, 1'b0);
        step("lk4", rd(12'h010, 1'b0), idle(), 1'b0, 1'b0);
`endif
        step("lk5", idle(), rd(12'h020, 1'b0), 1'b0, 1'b0);

        step("drain1", idle(), idle(), 1'b0, 1'b0);
        step("drain2", idle(), idle(), 1'b0, 1'b0);
        step("drain3", idle(), idle(), 1'b0, 1'b0);
        #3;
        check("q0_empty", q0.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
